// File: rtl/spi_rx_pkg.sv
`default_nettype none
// spi_rx_pkg: shared types and constants for the SPI frame receiver.
package spi_rx_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HEADER  = 3'd1,
      PAYLOAD = 3'd2,
      LABEL   = 3'd3,
      DONE    = 3'd4,
      WAIT_SS = 3'd5
   } rx_state_t;

   localparam int HDR_TRAIN_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/spi_bit_deser.sv
`default_nettype none
// spi_bit_deser: synchronises the SPI pins, samples MOSI on SCK rising edges
// and emits a one-cycle word_done pulse with the assembled word.
module spi_bit_deser #(
   parameter int DATA_W      = 8,
   parameter int LSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              ss_n,
   input  logic              mosi,
   output logic [DATA_W-1:0] word,
   output logic              word_done,
   output logic              ss_fall,
   output logic              ss_rise,
   output logic              ss_high
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_prev;
   logic                   ss_prev;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      shift_next;
   logic                   sck_cur;
   logic                   ss_cur;
   logic                   mosi_cur;
   logic                   sck_rise;

   assign sck_cur  = sck_sync[SYNC_STAGES-1];
   assign ss_cur   = ss_sync[SYNC_STAGES-1];
   assign mosi_cur = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = ~sck_prev & sck_cur;
   assign ss_high  = ss_cur;

   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign shift_next = {mosi_cur, word[DATA_W-1:1]};
      end else begin : g_msb_first
         assign shift_next = {word[DATA_W-2:0], mosi_cur};
      end
   endgenerate

   // Sync chains reset low so a select already asserted at reset release
   // produces no falling edge; the receiver waits for a fresh frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         ss_sync   <= '0;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
         ss_prev   <= 1'b0;
         bit_cnt   <= '0;
         word      <= '0;
         word_done <= 1'b0;
         ss_fall   <= 1'b0;
         ss_rise   <= 1'b0;
      end else begin
         sck_sync[0]  <= sck;
         ss_sync[0]   <= ss_n;
         mosi_sync[0] <= mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_sync[i]  <= sck_sync[i-1];
            ss_sync[i]   <= ss_sync[i-1];
            mosi_sync[i] <= mosi_sync[i-1];
         end
         sck_prev  <= sck_cur;
         ss_prev   <= ss_cur;
         ss_fall   <= ss_prev & ~ss_cur;
         ss_rise   <= ~ss_prev & ss_cur;
         word_done <= 1'b0;
         if (ss_cur) begin
            bit_cnt <= '0;
         end else if (sck_rise) begin
            word <= shift_next;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt   <= '0;
               word_done <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_frame_receiver.sv
`default_nettype none
// spi_frame_receiver: frames SPI words into header/payload/label, buffers
// payload words in a one-entry valid/ready register and decodes the label.
module spi_frame_receiver
   import spi_rx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int N_PAYLOAD   = 784,
   parameter int NUM_CLASSES = 10,
   parameter int LSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sck,
   input  logic                         ss_n,
   input  logic                         mosi,
   input  logic                         data_ready,
   output logic                         word_valid,
   output logic [DATA_W-1:0]            word_data,
   output logic [$clog2(N_PAYLOAD)-1:0] word_addr,
   output logic                         train_mode,
   output logic [NUM_CLASSES-1:0]       expected_label,
   output logic                         calculate_cost,
   output logic                         frame_done,
   output logic                         overrun,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int ADDR_W = $clog2(N_PAYLOAD);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_PAYLOAD - 1);
   localparam logic [DATA_W:0]   CLASS_LIMIT = (DATA_W + 1)'(NUM_CLASSES);

   rx_state_t               state;
   rx_state_t               state_next;
   logic [DATA_W-1:0]       word;
   logic                    word_done;
   logic                    ss_fall;
   logic                    ss_rise;
   logic                    ss_high;
   logic                    accept;
   logic                    abort;
   logic                    done_now;
   logic                    label_ok;
   logic [ADDR_W-1:0]       addr_cnt;
   logic [NUM_CLASSES-1:0]  label_onehot;

   spi_bit_deser #(
      .DATA_W      (DATA_W),
      .LSB_FIRST   (LSB_FIRST),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_deser (
      .clk       (clk),
      .rst       (rst),
      .sck       (sck),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .word      (word),
      .word_done (word_done),
      .ss_fall   (ss_fall),
      .ss_rise   (ss_rise),
      .ss_high   (ss_high)
   );

   assign accept       = word_done & ~ss_rise;
   assign label_onehot = {{(NUM_CLASSES-1){1'b0}}, 1'b1} << word;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      abort      = 1'b0;
      done_now   = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) state_next = HEADER;
         end
         HEADER: begin
            if (ss_rise) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (word_done) begin
               state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (ss_rise) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (word_done && addr_cnt == LAST_ADDR) begin
               state_next = train_mode ? LABEL : DONE;
            end
         end
         LABEL: begin
            if (ss_rise) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (word_done) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Hold off completion until the last payload word has been taken.
            if (!word_valid) begin
               done_now   = 1'b1;
               state_next = WAIT_SS;
            end
         end
         WAIT_SS: begin
            if (ss_high) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_valid     <= 1'b0;
         word_data      <= '0;
         word_addr      <= '0;
         train_mode     <= 1'b0;
         expected_label <= '0;
         calculate_cost <= 1'b0;
         frame_done     <= 1'b0;
         overrun        <= 1'b0;
         frame_err      <= 1'b0;
         label_ok       <= 1'b0;
         addr_cnt       <= '0;
      end else begin
         frame_done     <= done_now;
         calculate_cost <= done_now & train_mode & label_ok;
         if (word_valid && data_ready) word_valid <= 1'b0;
         if (abort) frame_err <= 1'b1;
         case (state)
            HEADER: begin
               if (accept) begin
                  train_mode     <= word[HDR_TRAIN_BIT];
                  expected_label <= '0;
                  label_ok       <= 1'b0;
                  overrun        <= 1'b0;
                  frame_err      <= 1'b0;
                  addr_cnt       <= '0;
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  // A word arriving on the transfer cycle refills the slot directly.
                  if (!word_valid || data_ready) begin
                     word_valid <= 1'b1;
                     word_data  <= word;
                     word_addr  <= addr_cnt;
                  end else begin
                     overrun <= 1'b1;
                  end
                  if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + 1'b1;
               end
            end
            LABEL: begin
               if (accept) begin
                  if ({1'b0, word} < CLASS_LIMIT) begin
                     expected_label <= label_onehot;
                     label_ok       <= 1'b1;
                  end else begin
                     expected_label <= '0;
                     label_ok       <= 1'b0;
                     frame_err      <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_receiver.sv
`timescale 1ns/1ps
// Directed bench for spi_frame_receiver with a 4-word payload; a second
// instance receives MSB-first.
module tb_spi_frame_receiver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sck = 1'b0;
   logic ss_n = 1'b1;
   logic mosi = 1'b0;
   logic data_ready = 1'b1;

   always #5 clk = ~clk;

   logic       word_valid, train_mode, calculate_cost, frame_done, overrun, frame_err, busy;
   logic [7:0] word_data;
   logic [1:0] word_addr;
   logic [9:0] expected_label;

   logic       m_word_valid, m_train_mode, m_calculate_cost, m_frame_done, m_overrun, m_frame_err, m_busy;
   logic [7:0] m_word_data;
   logic [1:0] m_word_addr;
   logic [9:0] m_expected_label;

   spi_frame_receiver #(
      .DATA_W(8), .N_PAYLOAD(4), .NUM_CLASSES(10), .LSB_FIRST(1), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .data_ready(data_ready),
      .word_valid(word_valid), .word_data(word_data), .word_addr(word_addr),
      .train_mode(train_mode), .expected_label(expected_label),
      .calculate_cost(calculate_cost), .frame_done(frame_done),
      .overrun(overrun), .frame_err(frame_err), .busy(busy)
   );

   spi_frame_receiver #(
      .DATA_W(8), .N_PAYLOAD(4), .NUM_CLASSES(10), .LSB_FIRST(0), .SYNC_STAGES(2)
   ) dut_msb (
      .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .data_ready(data_ready),
      .word_valid(m_word_valid), .word_data(m_word_data), .word_addr(m_word_addr),
      .train_mode(m_train_mode), .expected_label(m_expected_label),
      .calculate_cost(m_calculate_cost), .frame_done(m_frame_done),
      .overrun(m_overrun), .frame_err(m_frame_err), .busy(m_busy)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0] q_data[$];
   logic [1:0] q_addr[$];
   logic [7:0] m_data[$];
   int fd_cnt = 0;
   int cc_cnt = 0;
   int cyc = 0;
   int last_xfer_cyc = 0;
   int last_fd_cyc = 0;

   // Transfer/pulse recorder; the directed sequence below judges what it saw.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (word_valid && data_ready) begin
            q_data.push_back(word_data);
            q_addr.push_back(word_addr);
            last_xfer_cyc = cyc;
         end
         if (m_word_valid && data_ready) m_data.push_back(m_word_data);
         if (frame_done) begin
            fd_cnt++;
            last_fd_cyc = cyc;
         end
         if (calculate_cost) cc_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit msb_first);
      for (int i = 0; i < 8; i++) begin
         mosi = msb_first ? b[7-i] : b[i];
         #50 sck = 1'b1;
         #50 sck = 1'b0;
      end
   endtask

   task automatic start_frame();
      ss_n = 1'b0;
      #100;
   endtask

   task automatic end_frame();
      #100 ss_n = 1'b1;
      #300;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 data_ready = v;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3,
                             input bit with_label, input logic [7:0] label, input bit msb);
      start_frame();
      send_byte(hdr, msb);
      send_byte(w0, msb);
      send_byte(w1, msb);
      send_byte(w2, msb);
      send_byte(w3, msb);
      if (with_label) send_byte(label, msb);
      end_frame();
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_word_valid", {31'd0, word_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_label", {22'd0, expected_label}, 32'd0);
      check("rst_flags", {28'd0, overrun, frame_err, frame_done, calculate_cost}, 32'd0);
      rst = 1'b0;
      #100;

      // Inference frame
      q_data.delete(); q_addr.delete();
      send_frame(8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 1'b0, 8'h00, 1'b0);
      check("inf_count", q_data.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("inf_data", {24'd0, q_data[i]}, 32'h11 + i);
         check("inf_addr", {30'd0, q_addr[i]}, i);
      end
      check("inf_frame_done", fd_cnt, 32'd1);
      check("inf_cost", cc_cnt, 32'd0);
      check("inf_done_after_xfer", {31'd0, last_fd_cyc > last_xfer_cyc}, 32'd1);
      check("inf_idle", {31'd0, busy}, 32'd0);

      // Training frame, label 7
      q_data.delete(); q_addr.delete();
      send_frame(8'h01, 8'h21, 8'h22, 8'h23, 8'h24, 1'b1, 8'd7, 1'b0);
      check("trn_count", q_data.size(), 32'd4);
      check("trn_mode", {31'd0, train_mode}, 32'd1);
      check("trn_label", {22'd0, expected_label}, 32'h080);
      check("trn_cost", cc_cnt, 32'd1);
      check("trn_frame_done", fd_cnt, 32'd2);
      check("trn_cost_after_xfer", {31'd0, last_fd_cyc > last_xfer_cyc}, 32'd1);
      check("trn_err", {31'd0, frame_err}, 32'd0);

      // Backpressure: second word dropped while the first is held
      q_data.delete(); q_addr.delete();
      set_ready(1'b0);
      start_frame();
      send_byte(8'h00, 1'b0);
      send_byte(8'h31, 1'b0);
      #100;
      check("bp_valid", {31'd0, word_valid}, 32'd1);
      check("bp_data1", {24'd0, word_data}, 32'h31);
      check("bp_overrun_pre", {31'd0, overrun}, 32'd0);
      send_byte(8'h32, 1'b0);
      #100;
      check("bp_data_held", {24'd0, word_data}, 32'h31);
      check("bp_addr_held", {30'd0, word_addr}, 32'd0);
      check("bp_overrun", {31'd0, overrun}, 32'd1);
      set_ready(1'b1);
      send_byte(8'h33, 1'b0);
      send_byte(8'h34, 1'b0);
      end_frame();
      check("bp_count", q_data.size(), 32'd3);
      check("bp_q0", {22'd0, q_addr[0], q_data[0]}, 32'h031);
      check("bp_q1", {22'd0, q_addr[1], q_data[1]}, 32'h233);
      check("bp_q2", {22'd0, q_addr[2], q_data[2]}, 32'h334);
      check("bp_frame_done", fd_cnt, 32'd3);
      check("bp_overrun_sticky", {31'd0, overrun}, 32'd1);

      // SS abort after two payload words
      q_data.delete(); q_addr.delete();
      start_frame();
      send_byte(8'h01, 1'b0);
      send_byte(8'h41, 1'b0);
      send_byte(8'h42, 1'b0);
      #100 ss_n = 1'b1;
      #300;
      check("abort_err", {31'd0, frame_err}, 32'd1);
      check("abort_idle", {31'd0, busy}, 32'd0);
      check("abort_no_done", fd_cnt, 32'd3);
      check("abort_overrun_cleared", {31'd0, overrun}, 32'd0);
      check("abort_count", q_data.size(), 32'd2);

      // Recovery frame clears the error
      q_data.delete(); q_addr.delete();
      send_frame(8'h00, 8'h51, 8'h52, 8'h53, 8'h54, 1'b0, 8'h00, 1'b0);
      check("recover_err", {31'd0, frame_err}, 32'd0);
      check("recover_done", fd_cnt, 32'd4);
      check("recover_last", {22'd0, q_addr[3], q_data[3]}, 32'h354);

      // Out-of-range label
      send_frame(8'h01, 8'h61, 8'h62, 8'h63, 8'h64, 1'b1, 8'd12, 1'b0);
      check("badlbl_err", {31'd0, frame_err}, 32'd1);
      check("badlbl_label", {22'd0, expected_label}, 32'd0);
      check("badlbl_done", fd_cnt, 32'd5);
      check("badlbl_cost", cc_cnt, 32'd1);

      // Reset in the middle of the payload
      set_ready(1'b0);
      start_frame();
      send_byte(8'h01, 1'b0);
      send_byte(8'h71, 1'b0);
      #100;
      check("midrst_pre_valid", {31'd0, word_valid}, 32'd1);
      check("midrst_pre_mode", {31'd0, train_mode}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_valid", {31'd0, word_valid}, 32'd0);
      check("midrst_data", {22'd0, word_addr, word_data}, 32'd0);
      check("midrst_mode", {31'd0, train_mode}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_flags", {18'd0, expected_label, overrun, frame_err, frame_done, calculate_cost}, 32'd0);
      rst = 1'b0;
      ss_n = 1'b1;
      set_ready(1'b1);
      #300;

      // MSB-first instance
      q_data.delete(); q_addr.delete(); m_data.delete();
      send_frame(8'h00, 8'hA5, 8'h12, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      check("msb_count", m_data.size(), 32'd4);
      check("msb_w0", {24'd0, m_data[0]}, 32'hA5);
      check("msb_w1", {24'd0, m_data[1]}, 32'h12);
      check("lsb_view_w1", {24'd0, q_data[1]}, 32'h48);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
